// File: rtl/psum_accumulator_bank.sv
// psum_accumulator_bank: per-column partial-sum accumulator bank with a
// sequenced valid/ready drain that streams every entry in address order and
// clears each entry as it is accepted.
// Optional build macro ACC_SAT_EN: accumulation saturates at 2^PSUM_W-1
// instead of wrapping, and the extra sat_flag output pulses on saturation.
module psum_accumulator_bank #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PSUM_W = 45,
    parameter int unsigned COMP_W = 13,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_wr_en,
    input  logic [ADDR_W-1:0] acc_wr_addr,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              cacc_wr_en,
    input  logic [ADDR_W-1:0] cacc_wr_addr,
    input  logic [COMP_W-1:0] comp_psum_in,
    input  logic              drain_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [PSUM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              wr_drop
`ifdef ACC_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [PSUM_W-1:0] mem      [DEPTH];
    logic [PSUM_W-1:0] base     [DEPTH];
    logic [PSUM_W-1:0] mem_nxt  [DEPTH];
    logic [PSUM_W-1:0] comp_ext;
    logic [ADDR_W-1:0] nxt_addr;
`ifdef ACC_SAT_EN
    logic [PSUM_W:0]   sum_ext  [DEPTH];
    logic [DEPTH-1:0]  sat_vec;
`endif

    assign comp_ext = PSUM_W'(comp_psum_in);
    assign nxt_addr = out_addr + ADDR_W'(1);

    // Post-write value of every entry if this cycle's requests were applied;
    // a same-address preload replaces the old value before the add.
    always_comb begin
`ifdef ACC_SAT_EN
        sat_vec = '0;
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            base[i] = (cacc_wr_en && (cacc_wr_addr == ADDR_W'(i))) ? comp_ext : mem[i];
            mem_nxt[i] = base[i];
`ifdef ACC_SAT_EN
            sum_ext[i] = {1'b0, base[i]} + {1'b0, psum_in};
            if (acc_wr_en && (acc_wr_addr == ADDR_W'(i))) begin
                if (sum_ext[i][PSUM_W]) begin
                    mem_nxt[i] = '1;
                    sat_vec[i] = 1'b1;
                end else begin
                    mem_nxt[i] = sum_ext[i][PSUM_W-1:0];
                end
            end
`else
            if (acc_wr_en && (acc_wr_addr == ADDR_W'(i))) begin
                mem_nxt[i] = base[i] + psum_in;
            end
`endif
        end
    end

    // Entry storage: writes only in IDLE, clear-on-read during DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (state == IDLE) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= mem_nxt[i];
            end
        end else if (out_ready) begin
            mem[out_addr] <= '0;
        end
    end

    // Drain FSM with registered beat outputs; out_addr doubles as read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_addr  <= '0;
                        // First beat must reflect writes accepted this cycle.
                        out_data  <= mem_nxt[0];
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    wr_drop <= acc_wr_en | cacc_wr_en;
                    if (out_ready) begin
                        if (out_addr == LAST_ADDR) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_addr  <= '0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            out_addr  <= nxt_addr;
                            out_data  <= mem[nxt_addr];
                            out_last  <= (nxt_addr == LAST_ADDR);
                        end
                    end
                end
            endcase
        end
    end

`ifdef ACC_SAT_EN
    // One-cycle pulse when an accepted accumulate clipped at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= (state == IDLE) && (|sat_vec);
        end
    end
`endif

endmodule

// File: tb/tb_psum_accumulator_bank.sv
// Scoreboard bench for psum_accumulator_bank: a driver updates an array model
// and queues the expected drain beats; a negedge monitor compares each beat.
module tb_psum_accumulator_bank;

    localparam int DEPTH  = 8;
    localparam int PSUM_W = 45;
    localparam int COMP_W = 13;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [PSUM_W-1:0] MAXV = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_wr_en;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic [PSUM_W-1:0] psum_in;
    logic              cacc_wr_en;
    logic [ADDR_W-1:0] cacc_wr_addr;
    logic [COMP_W-1:0] comp_psum_in;
    logic              drain_start;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [PSUM_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              wr_drop;
`ifdef ACC_SAT_EN
    logic              sat_flag;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PSUM_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             sb_q[$];
    logic [PSUM_W-1:0] mdl [DEPTH];
    int                n_cmp = 0;
    int                n_err = 0;

    psum_accumulator_bank #(
        .DEPTH (DEPTH),
        .PSUM_W(PSUM_W),
        .COMP_W(COMP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_wr_en   (acc_wr_en),
        .acc_wr_addr (acc_wr_addr),
        .psum_in     (psum_in),
        .cacc_wr_en  (cacc_wr_en),
        .cacc_wr_addr(cacc_wr_addr),
        .comp_psum_in(comp_psum_in),
        .drain_start (drain_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .wr_drop     (wr_drop)
`ifdef ACC_SAT_EN
        ,
        .sat_flag    (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        acc_wr_en    = 1'b0;
        acc_wr_addr  = '0;
        psum_in      = '0;
        cacc_wr_en   = 1'b0;
        cacc_wr_addr = '0;
        comp_psum_in = '0;
        drain_start  = 1'b0;
    endtask

    // Reference arithmetic: preload overwrites, then the partial sum is added.
    task automatic model_write(input bit ae, input int aa, input logic [PSUM_W-1:0] p,
                               input bit ce, input int ca, input logic [COMP_W-1:0] c,
                               output bit sat);
        logic [PSUM_W:0] s;
        sat = 1'b0;
        if (ce) mdl[ca] = PSUM_W'(c);
        if (ae) begin
            s = {1'b0, mdl[aa]} + {1'b0, p};
            if (s > {1'b0, MAXV}) begin
`ifdef ACC_SAT_EN
                mdl[aa] = MAXV;
                sat = 1'b1;
`else
                mdl[aa] = s[PSUM_W-1:0];
`endif
            end else begin
                mdl[aa] = s[PSUM_W-1:0];
            end
        end
    endtask

    // A drain streams a snapshot of the model and leaves it all zero.
    task automatic push_drain();
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.addr = ADDR_W'(i);
            b.data = mdl[i];
            b.last = (i == DEPTH - 1);
            sb_q.push_back(b);
            mdl[i] = '0;
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // One IDLE-state write cycle, optionally together with drain_start.
    task automatic do_write(input bit ae, input int aa, input logic [PSUM_W-1:0] p,
                            input bit ce, input int ca, input logic [COMP_W-1:0] c,
                            input bit start);
        bit s;
        acc_wr_en    = ae;
        acc_wr_addr  = ADDR_W'(aa);
        psum_in      = p;
        cacc_wr_en   = ce;
        cacc_wr_addr = ADDR_W'(ca);
        comp_psum_in = c;
        drain_start  = start;
        model_write(ae, aa, p, ce, ca, c, s);
        if (start) push_drain();
        cycle();
        clear_inputs();
        chk("wr_drop_idle", 64'(wr_drop), 64'd0);
`ifdef ACC_SAT_EN
        chk("sat_flag", 64'(sat_flag), 64'(s));
`else
        if (s) $display("note: unexpected saturation in model");
`endif
    endtask

    task automatic rand_write(input bit start);
        logic [63:0]       r;
        logic [PSUM_W-1:0] p;
        r = {$urandom(), $urandom()};
        p = ($urandom_range(0, 3) == 0) ? PSUM_W'(r) : PSUM_W'($urandom_range(0, 100000));
        do_write(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), p,
                 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                 COMP_W'($urandom()), start);
    endtask

    // Wait out a drain. mode 0: ready held high, 1: ready 1,0,0 repeating,
    // 2: random ready. wr_mid issues discarded writes; rst_at>=0 resets
    // while that beat index is presented.
    task automatic run_drain(input int mode, input bit wr_mid, input int rst_at);
        int n;
        bit wr;
        n = 0;
        while (sb_q.size() != 0) begin
            if (rst_at >= 0 && (DEPTH - sb_q.size()) == rst_at) begin
                rst       = 1'b1;
                out_ready = 1'b0;
                cycle();
                rst = 1'b0;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_wr_drop", 64'(wr_drop), 64'd0);
                sb_q.delete();
                zero_model();
                return;
            end
            if (n > 50 * DEPTH) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: %0d beats outstanding after %0d cycles", sb_q.size(), n);
                sb_q.delete();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                zero_model();
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            wr = 1'b0;
            if (wr_mid && $urandom_range(0, 2) == 0) begin
                acc_wr_en    = 1'($urandom_range(0, 1));
                cacc_wr_en   = !acc_wr_en || 1'($urandom_range(0, 1));
                acc_wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
                cacc_wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                psum_in      = PSUM_W'($urandom());
                comp_psum_in = COMP_W'($urandom());
                drain_start  = 1'($urandom_range(0, 1));
                wr = 1'b1;
            end
            cycle();
            n++;
            clear_inputs();
            chk("wr_drop_drain", 64'(wr_drop), 64'(wr));
        end
        out_ready = 1'b0;
        chk("busy_after_drain", 64'(busy), 64'd0);
        chk("valid_after_drain", 64'(out_valid), 64'd0);
        if (mode == 0) chk("drain_cycles", 64'(n), 64'(DEPTH));
    endtask

    task automatic start_drain();
        do_write(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
    endtask

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got addr %0d data 0x%0h, none expected", out_addr, out_data);
            end else begin
                chk("beat_addr", 64'(out_addr), 64'(sb_q[0].addr));
                chk("beat_data", 64'(out_data), 64'(sb_q[0].data));
                chk("beat_last", 64'(out_last), 64'(sb_q[0].last));
                chk("beat_busy", 64'(busy), 64'd1);
                if (out_ready) sb_q.delete(0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        zero_model();
        repeat (3) cycle();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_addr", 64'(out_addr), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_last", 64'(out_last), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wr_drop", 64'(wr_drop), 64'd0);
        rst = 1'b0;
        cycle();

        // Post-reset drain: all zero, DEPTH cycles with ready held.
        start_drain();
        run_drain(0, 1'b0, -1);

        // Preload then two accumulates into one entry; then clear-on-read.
        do_write(1'b0, 0, '0, 1'b1, 3, 13'd100, 1'b0);
        do_write(1'b1, 3, 45'd5000, 1'b0, 0, '0, 1'b0);
        do_write(1'b1, 3, 45'd7, 1'b0, 0, '0, 1'b0);
        start_drain();
        run_drain(0, 1'b0, -1);
        start_drain();
        run_drain(0, 1'b0, -1);

        // Same-address and different-address dual writes; the last one
        // coincides with drain_start so the first beats must include it.
        do_write(1'b0, 0, '0, 1'b1, 2, 13'd77, 1'b0);
        do_write(1'b1, 2, 45'd40, 1'b1, 2, 13'd9, 1'b0);
        do_write(1'b1, 6, 45'd10, 1'b1, 1, 13'd4, 1'b1);
        run_drain(0, 1'b0, -1);

        // Stalled drain with discarded writes, then confirm nothing leaked.
        for (int i = 0; i < DEPTH; i++) do_write(1'b1, i, PSUM_W'(i * 1000 + 1), 1'b0, 0, '0, 1'b0);
        start_drain();
        run_drain(1, 1'b1, -1);
        start_drain();
        run_drain(0, 1'b0, -1);

        // Reset in the middle of a drain abandons it and clears everything.
        for (int i = 0; i < 6; i++) rand_write(1'b0);
        start_drain();
        run_drain(0, 1'b0, 4);
        start_drain();
        run_drain(0, 1'b0, -1);

        // Near full-scale accumulate: wraps, or clips with sat_flag.
        do_write(1'b1, 5, MAXV - 45'd2, 1'b0, 0, '0, 1'b0);
        do_write(1'b1, 5, 45'd10, 1'b0, 0, '0, 1'b0);
        do_write(1'b1, 0, 45'd1, 1'b0, 0, '0, 1'b0);
        start_drain();
        run_drain(0, 1'b0, -1);

        // Random traffic with random backpressure and mid-drain writes.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 12; k++) rand_write(1'b0);
            rand_write(1'b1);
            run_drain(2, 1'b1, -1);
        end

        repeat (3) cycle();
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
